rr_arbiter_n: RTL

RR_ARBITER_N -- requirements
Module: rr_arbiter_n

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_rr_pick.sv | 30 +++
 rtl/rr_arbiter_n.sv | 98 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the arbiter family: mode encodings and legal parameter ranges.
package arb_pkg;

  localparam int unsigned ARB_MODE_RR    = 0;
  localparam int unsigned ARB_MODE_FIXED = 1;

  localparam int unsigned ARB_N_REQ_MIN    = 2;
  localparam int unsigned ARB_N_REQ_MAX    = 16;
  localparam int unsigned ARB_MAX_HOLD_MIN = 1;
  localparam int unsigned ARB_MAX_HOLD_MAX = 255;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotating scan: first set req bit at or after start, wrapping at N_REQ.
module arb_rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [N_REQ-1:0] onehot_c,
  output logic [IDX_W-1:0] idx_c
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(start) + i) % N_REQ);
      if (!found && req[cand]) begin
        found          = 1'b1;
        onehot_c[cand] = 1'b1;
        idx_c          = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way arbiter with registered one-hot grant, bounded hold under contention,
// and selectable round-robin or fixed-priority winner selection.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned FIXED_PRIO = ARB_MODE_RR
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           grant,
  output logic                       grant_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_REQ - 1);

  if (N_REQ < ARB_N_REQ_MIN || N_REQ > ARB_N_REQ_MAX) begin : g_bad_n_req
    $error("rr_arbiter_n: N_REQ=%0d outside legal range", N_REQ);
  end
  if (MAX_HOLD < ARB_MAX_HOLD_MIN || MAX_HOLD > ARB_MAX_HOLD_MAX) begin : g_bad_max_hold
    $error("rr_arbiter_n: MAX_HOLD=%0d outside legal range", MAX_HOLD);
  end
  if (FIXED_PRIO != ARB_MODE_RR && FIXED_PRIO != ARB_MODE_FIXED) begin : g_bad_mode
    $error("rr_arbiter_n: FIXED_PRIO=%0d is not a known mode", FIXED_PRIO);
  end

  logic [IDX_W-1:0]  last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  grant_d;
  logic              valid_d;
  logic [IDX_W-1:0]  id_d;

  logic [IDX_W-1:0]  start_c;
  logic [N_REQ-1:0]  pick_onehot_c;
  logic [IDX_W-1:0]  pick_idx_c;
  logic              others_c;
  logic              keep_c;

  // Fixed priority always scans from 0; round-robin starts just past the last winner.
  assign start_c = (FIXED_PRIO == ARB_MODE_FIXED) ? '0 :
                   (last_q == LAST_IDX)           ? '0 : last_q + IDX_W'(1);

  arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req),
    .start    (start_c),
    .onehot_c (pick_onehot_c),
    .idx_c    (pick_idx_c)
  );

  assign others_c = |(req & ~grant);
  assign keep_c   = grant_valid && req[grant_id] && ((hold_q < HOLD_LIMIT) || !others_c);

  always_comb begin
    grant_d = grant;
    valid_d = grant_valid;
    id_d    = grant_id;
    last_d  = last_q;
    hold_d  = hold_q;
    if (keep_c) begin
      hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
    end else if (|req) begin
      grant_d = pick_onehot_c;
      valid_d = 1'b1;
      id_d    = pick_idx_c;
      last_d  = pick_idx_c;
      hold_d  = '0;
    end else begin
      grant_d = '0;
      valid_d = 1'b0;
      id_d    = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_q      <= LAST_IDX;
      hold_q      <= '0;
    end else begin
      grant       <= grant_d;
      grant_valid <= valid_d;
      grant_id    <= id_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
    end
  end

endmodule
